// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared definitions for the pipe_stage_reg family.
//            - occupancy state enum of the stage FSM
//            - stall-counter width
//            - canonical control/payload widths of every inter-stage latch,
//              so each stage instance is built with identical widths
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Occupancy of a pipeline stage: no entry, main only, main + skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  localparam int STALL_CNT_W = 32;

  // IF/ID : pc, pc+4, instruction
  localparam int IFID_CTRL_W  = 4;
  localparam int IFID_DATA_W  = 96;
  // ID/EX : pc, rs1/rs2 values, immediate, register indices, pc+4, spare
  localparam int IDEX_CTRL_W  = 16;
  localparam int IDEX_DATA_W  = 192;
  // EX/MEM: alu result, store data, pc+4, rd index
  localparam int EXMEM_CTRL_W = 8;
  localparam int EXMEM_DATA_W = 101;
  // MEM/WB: load data, alu result, rd index
  localparam int MEMWB_CTRL_W = 4;
  localparam int MEMWB_DATA_W = 69;

  // True when the stage currently presents an entry downstream.
  function automatic logic stage_has_entry(input pipe_state_e s);
    return (s != ST_EMPTY);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_entry_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_entry_reg
// Purpose  : One pipeline entry (control + payload) with independent clears.
//            Clears take priority over Load so a flush always wins.
// Ports    : Clk       in   rising-edge clock
//            Reset_n   in   asynchronous active-low reset (all zero)
//            Load      in   capture In_Ctrl / In_Data
//            Clr_Ctrl  in   zero the control field
//            Clr_Data  in   zero the payload field
//            In_Ctrl   in   CTRL_W control to capture
//            In_Data   in   DATA_W payload to capture
//            Out_Ctrl  out  CTRL_W held control
//            Out_Data  out  DATA_W held payload
// Revision : 1.0 - initial release
// ============================================================================
module pipe_entry_reg #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 192
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Load,
  input  logic              Clr_Ctrl,
  input  logic              Clr_Data,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Data,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [DATA_W-1:0] Out_Data
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (Clr_Ctrl) begin
      ctrl_d = '0;
    end else if (Load) begin
      ctrl_d = In_Ctrl;
    end
    if (Clr_Data) begin
      data_d = '0;
    end else if (Load) begin
      data_d = In_Data;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign Out_Ctrl = ctrl_q;
  assign Out_Data = data_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Reusable pipeline-stage register with valid/ready handshake,
//            flush-to-bubble and optional two-entry skid buffer.
//            Control fields are zero whenever no valid entry is held.
// Params   : CTRL_W, DATA_W  field widths
//            SKID            1 = two entries, registered In_Ready
//                            0 = one entry, In_Ready = Out_Ready | ~Out_Valid
//            CLEAR_ON_FLUSH  1 = payload zeroed on flush, 0 = payload held
// Ports    : Clk, Reset_n (async active-low), Flush
//            In_Valid / In_Ready / In_Ctrl / In_Data     upstream side
//            Out_Valid / Out_Ready / Out_Ctrl / Out_Data downstream side
//            Stall_Count  out 32  cycles with Out_Valid & ~Out_Ready
// Macro    : PIPE_STAGE_STATS_EN - adds Stall_Count port and counter
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W         = 16,
  parameter int DATA_W         = 192,
  parameter int SKID           = 1,
  parameter int CLEAR_ON_FLUSH = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [DATA_W-1:0] Out_Data
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] Stall_Count
`endif
);

  pipe_state_e state_q, state_d;

  logic              out_valid;
  logic              in_xfer;
  logic              out_xfer;

  logic              main_load;
  logic              main_from_skid;
  logic              main_clr_ctrl;
  logic              main_clr_data;
  logic [CTRL_W-1:0] main_in_ctrl;
  logic [DATA_W-1:0] main_in_data;

  logic              skid_load;
  logic              skid_clr_ctrl;
  logic              skid_clr_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign out_valid = stage_has_entry(state_q);
  assign Out_Valid = out_valid;

  // An input offered during a flush is dropped, so it never counts as taken.
  assign in_xfer  = In_Valid & In_Ready & ~Flush;
  assign out_xfer = out_valid & Out_Ready;

  // --------------------------------------------------------------------------
  // Occupancy FSM: next state plus load/clear strobes for both entries.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clr_ctrl  = 1'b0;
    main_clr_data  = 1'b0;
    skid_load      = 1'b0;
    skid_clr_ctrl  = 1'b0;
    skid_clr_data  = 1'b0;

    if (Flush) begin
      // Any out-transfer this cycle has already been sampled downstream.
      state_d       = ST_EMPTY;
      main_clr_ctrl = 1'b1;
      skid_clr_ctrl = 1'b1;
      main_clr_data = (CLEAR_ON_FLUSH != 0);
      skid_clr_data = (CLEAR_ON_FLUSH != 0);
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_load = 1'b1;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          case ({in_xfer, out_xfer})
            2'b11: begin
              main_load = 1'b1;
            end
            2'b10: begin
              // Without a skid, In_Ready implies Out_Ready here, so this
              // combination only arises in the two-entry build.
              if (SKID != 0) begin
                skid_load = 1'b1;
                state_d   = ST_TWO;
              end
            end
            2'b01: begin
              // Leaving a bubble: control must read as zero, payload kept.
              main_clr_ctrl = 1'b1;
              state_d       = ST_EMPTY;
            end
            default: begin
              state_d = ST_ONE;
            end
          endcase
        end
        ST_TWO: begin
          if (out_xfer) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr_ctrl  = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Main entry reloads from the skid on a drain, otherwise from upstream.
  assign main_in_ctrl = main_from_skid ? skid_ctrl : In_Ctrl;
  assign main_in_data = main_from_skid ? skid_data : In_Data;

  pipe_entry_reg #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Load     (main_load),
    .Clr_Ctrl (main_clr_ctrl),
    .Clr_Data (main_clr_data),
    .In_Ctrl  (main_in_ctrl),
    .In_Data  (main_in_data),
    .Out_Ctrl (Out_Ctrl),
    .Out_Data (Out_Data)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q, in_ready_d;

      // Ready is a flop so upstream never sees a combinational path from
      // Out_Ready; the skid entry absorbs the transfer already in flight.
      assign in_ready_d = (state_d != ST_TWO);

      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= in_ready_d;
        end
      end

      assign In_Ready = in_ready_q;

      pipe_entry_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
      ) u_skid (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Load     (skid_load),
        .Clr_Ctrl (skid_clr_ctrl),
        .Clr_Data (skid_clr_data),
        .In_Ctrl  (In_Ctrl),
        .In_Data  (In_Data),
        .Out_Ctrl (skid_ctrl),
        .Out_Data (skid_data)
      );
    end else begin : g_no_skid
      logic unused_skid;

      assign In_Ready    = Out_Ready | ~out_valid;
      assign skid_ctrl   = '0;
      assign skid_data   = '0;
      assign unused_skid = ^{skid_load, skid_clr_ctrl, skid_clr_data};
    end
  endgenerate

`ifdef PIPE_STAGE_STATS_EN
  // Back-pressure counter: saturating, immune to Flush, cleared by reset.
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (out_valid && !Out_Ready && (stall_count_q != {STALL_CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign Stall_Count = stall_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Self-checking bench for pipe_stage_reg. Two instances run side
//            by side: index 0 = skid build with payload clear on flush,
//            index 1 = single-entry build with payload held on flush.
//            Each is compared every cycle against a FIFO-occupancy model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int CW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          in_valid  [2];
  logic          flush     [2];
  logic          out_ready [2];
  logic [CW-1:0] in_ctrl   [2];
  logic [DW-1:0] in_data   [2];
  logic          in_ready  [2];
  logic          out_valid [2];
  logic [CW-1:0] out_ctrl  [2];
  logic [DW-1:0] out_data  [2];
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0]   stall_cnt [2];
`endif

  pipe_stage_reg #(
    .CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLEAR_ON_FLUSH(1)
  ) u_dut_skid (
    .Clk(clk), .Reset_n(rst_n), .Flush(flush[0]),
    .In_Valid(in_valid[0]), .In_Ready(in_ready[0]),
    .In_Ctrl(in_ctrl[0]), .In_Data(in_data[0]),
    .Out_Valid(out_valid[0]), .Out_Ready(out_ready[0]),
    .Out_Ctrl(out_ctrl[0]), .Out_Data(out_data[0])
`ifdef PIPE_STAGE_STATS_EN
    , .Stall_Count(stall_cnt[0])
`endif
  );

  pipe_stage_reg #(
    .CTRL_W(CW), .DATA_W(DW), .SKID(0), .CLEAR_ON_FLUSH(0)
  ) u_dut_flat (
    .Clk(clk), .Reset_n(rst_n), .Flush(flush[1]),
    .In_Valid(in_valid[1]), .In_Ready(in_ready[1]),
    .In_Ctrl(in_ctrl[1]), .In_Data(in_data[1]),
    .Out_Valid(out_valid[1]), .Out_Ready(out_ready[1]),
    .Out_Ctrl(out_ctrl[1]), .Out_Data(out_data[1])
`ifdef PIPE_STAGE_STATS_EN
    , .Stall_Count(stall_cnt[1])
`endif
  );

  // -------------------------------------------------------------- model ----
  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq    [2][2];   // FIFO contents, [k][0] is the head
  int            mcnt  [2];      // entries held
  logic [DW-1:0] mhold [2];      // payload visible while empty
  logic [31:0]   mstall[2];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic m_ready(input int k);
    if (k == 0) return (mcnt[0] < 2);
    return (mcnt[1] == 0) || out_ready[1];
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k]   = 0;
      mhold[k]  = '0;
      mstall[k] = '0;
    end
  endtask

  // One clock edge of the reference behaviour for instance k.
  task automatic m_step(input int k);
    logic rdy, ox, ix;
    ent_t e;
    rdy = m_ready(k);
    ox  = (mcnt[k] > 0) && out_ready[k];
    ix  = in_valid[k] && rdy && !flush[k];
    if ((mcnt[k] > 0) && !out_ready[k] && (mstall[k] != 32'hFFFF_FFFF)) mstall[k]++;
    if (ox) begin
      mq[k][0] = mq[k][1];
      mcnt[k]--;
    end
    if (flush[k]) begin
      mcnt[k] = 0;
      if (k == 0) mhold[k] = '0;
    end else if (ix) begin
      e.c = in_ctrl[k];
      e.d = in_data[k];
      mq[k][mcnt[k]] = e;
      mcnt[k]++;
    end
    if (mcnt[k] > 0) mhold[k] = mq[k][0].d;
  endtask

  task automatic cmp(input int k);
    string p;
    logic  v;
    p = (k == 0) ? "skid" : "flat";
    v = (mcnt[k] > 0);
    chk({p, ".out_valid"}, 64'(out_valid[k]), 64'(v));
    chk({p, ".out_ctrl"},  64'(out_ctrl[k]),  v ? 64'(mq[k][0].c) : 64'd0);
    chk({p, ".out_data"},  64'(out_data[k]),  v ? 64'(mq[k][0].d) : 64'(mhold[k]));
    chk({p, ".in_ready"},  64'(in_ready[k]),  64'(m_ready(k)));
`ifdef PIPE_STAGE_STATS_EN
    chk({p, ".stall_cnt"}, 64'(stall_cnt[k]), 64'(mstall[k]));
`endif
  endtask

  // ---------------------------------------------------------- stimulus ----
  task automatic drive(input int k, input logic v, input logic [CW-1:0] c,
                       input logic [DW-1:0] d, input logic ordy, input logic fl);
    in_valid[k]  = v;
    in_ctrl[k]   = c;
    in_data[k]   = d;
    out_ready[k] = ordy;
    flush[k]     = fl;
  endtask

  task automatic drive_rand(input int k);
    drive(k, $urandom_range(0, 9) < 7, CW'($urandom), DW'($urandom),
          $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
  endtask

  // Advance one edge, then check both instances away from the edge.
  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) m_step(k);
    for (int k = 0; k < 2; k++) cmp(k);
  endtask

  // Reset pulsed in the middle of the high phase: outputs must clear at once.
  task automatic async_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    for (int k = 0; k < 2; k++) cmp(k);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) cmp(k);
  endtask

  initial begin
    rst_n = 1'b0;
    m_reset();
    for (int k = 0; k < 2; k++) drive(k, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) cmp(k);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) cmp(k);

    // Random traffic, then a reset with entries in flight.
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < 2; k++) drive_rand(k);
      cycle();
    end
    async_reset();

    // Skid build: 8 back-to-back entries with no back-pressure.
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'b1, CW'(i), DW'(32'hA0 + i), 1'b1, 1'b0);
      drive(1, 1'b0, '0, '0, 1'b1, 1'b0);
      cycle();
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 1'b0, '0, '0, 1'b1, 1'b0);
      cycle();
    end

    // Skid build: 4 stalled cycles with input pending, then drain.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, CW'(8'h10 + i), DW'(32'hB0 + i), 1'b0, 1'b0);
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b0, '0, '0, 1'b1, 1'b0);
      cycle();
    end

    // Fill skid to two entries and flat to one, then flush with input offered.
    for (int i = 0; i < 2; i++) begin
      drive(0, 1'b1, CW'(8'h20 + i), DW'(32'hC0 + i), 1'b0, 1'b0);
      drive(1, (i == 0), 8'h30, 32'hD0, 1'b0, 1'b0);
      cycle();
    end
    drive(0, 1'b1, 8'h7F, 32'hDEAD, 1'b0, 1'b1);
    drive(1, 1'b1, 8'h7E, 32'hBEEF, 1'b0, 1'b1);
    cycle();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 2; k++) drive(k, 1'b0, '0, '0, 1'b1, 1'b0);
      cycle();
    end

    // Flat build: Out_Ready toggling every cycle with input always offered.
    for (int i = 0; i < 12; i++) begin
      drive(1, 1'b1, CW'(8'h40 + i), DW'(32'hE0 + i), 1'(i % 2), 1'b0);
      drive(0, 1'b0, '0, '0, 1'b1, 1'b0);
      cycle();
    end

    // Randomised traffic on both instances.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) drive_rand(k);
      cycle();
    end

`ifdef PIPE_STAGE_STATS_EN
    // One entry held for 10 stalled cycles from a clean reset.
    async_reset();
    drive(0, 1'b1, 8'h55, 32'h55, 1'b0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle();
    drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (10) cycle();
    chk("skid.stall10", 64'(stall_cnt[0]), 64'd10);

    // Counter pushed near its limit must stick at all-ones.
    force u_dut_skid.stall_count_q = 32'hFFFF_FFFD;
    #1;
    release u_dut_skid.stall_count_q;
    mstall[0] = 32'hFFFF_FFFD;
    repeat (5) cycle();
    chk("skid.stall_sat", 64'(stall_cnt[0]), 64'hFFFF_FFFF);
`endif

    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 2; k++) drive(k, 1'b0, '0, '0, 1'b1, 1'b0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register with a valid/ready handshake, flush-to-bubble and optional two-entry skid buffer. It generalises the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into one reusable block. Each field is carried as either control (always zeroed in a bubble) or data (payload). It sits between any two processor stages and lets back-pressure stall upstream stages without a combinational ready chain.

## Interface
- CTRL_W, 16, control-field width; zero whenever the stage holds no valid entry
- DATA_W, 192, payload width (PCs, operands, offsets, register indices)
- SKID, 1, 1 = two-entry skid buffer with registered In_Ready; 0 = single entry with combinational In_Ready
- CLEAR_ON_FLUSH, 1, 1 = payload registers zeroed on flush; 0 = payload held, only valid/control cleared

Ports:
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- Flush  in  1  synchronous kill of all held entries and of the current input
- In_Valid  in  1  upstream entry present
- In_Ready  out  1  stage can accept this cycle
- In_Ctrl  in  CTRL_W  upstream control field
- In_Data  in  DATA_W  upstream payload
- Out_Valid  out  1  entry presented downstream
- Out_Ready  in  1  downstream accepts
- Out_Ctrl  out  CTRL_W  control to next stage
- Out_Data  out  DATA_W  payload to next stage
- Stall_Count  out  32  back-pressure cycle counter (only with PIPE_STAGE_STATS_EN)

## Operation
- Transfer in: In_Valid & In_Ready. Transfer out: Out_Valid & Out_Ready.
- Invariant: Out_Ctrl == 0 whenever Out_Valid == 0.
- SKID=1 state machine, states EMPTY, ONE, TWO:
  - EMPTY: in-transfer goes to ONE (main register loads input).
  - ONE, in only: goes to TWO (skid register loads input).
  - ONE, out only: goes to EMPTY.
  - ONE, in and out: stays in ONE (main register reloads from input).
  - TWO, out-transfer: goes to ONE (main register loads from skid).
  - TWO: In_Ready = 0, so no in-transfer is possible.
- SKID=1: In_Ready = (state != TWO), driven from a register.
- SKID=0: one entry. In_Ready = Out_Ready | ~Out_Valid. Main register loads on every in-transfer.
- Ordering is strictly FIFO. The skid entry is never presented before the main entry.
- Flush has priority over all transfers. On the next edge:
  - state goes to EMPTY and Out_Valid goes to 0;
  - all control registers are zeroed;
  - payload is zeroed if CLEAR_ON_FLUSH=1, otherwise held;
  - an input offered in the flush cycle is dropped.
- Flush while EMPTY: no effect other than the zeroing above.
- A simultaneous out-transfer in the flush cycle still completes (downstream has already sampled the entry).

## Timing
- Reset (Reset_n low, asynchronous): Out_Valid=0, Out_Ctrl=0, Out_Data=0, state EMPTY, skid cleared, Stall_Count=0.
- In_Ready after reset: 1 in both modes.
- Reset asserted mid-operation discards both entries immediately, with no clock required.
- Latency: an input accepted at edge N appears on Out_* after edge N, i.e. 1 cycle.
- Throughput: 1 entry per cycle while Out_Ready=1.
- SKID=1: In_Ready deasserts one cycle after the stage first refuses an out-transfer with an entry pending. The skid absorbs the entry in flight.
- SKID=1: In_Ready reasserts the cycle after the TWO-to-ONE drain.
- Out_* are held stable while Out_Valid=1 and Out_Ready=0.

## Configuration
- Macro PIPE_STAGE_STATS_EN:
  - Defined: Stall_Count port exists. It increments each cycle with Out_Valid & ~Out_Ready, saturates at 32'hFFFF_FFFF, is unaffected by Flush, and is cleared only by reset.
  - Undefined: the port and the counter are absent. Functional behaviour is identical.

## Structure
- Shared package pipe_pkg holds:
  - state enum {ST_EMPTY, ST_ONE, ST_TWO};
  - localparam STALL_CNT_W = 32;
  - per-stage CTRL_W/DATA_W constants (IFID_*, IDEX_*, EXMEM_*, MEMWB_*), so every stage instance uses the same widths.
- One sub-module, pipe_entry_reg: an entry register of CTRL_W+DATA_W bits with load, clear-control and clear-data inputs. It is instantiated for the main and skid entries.
- The FSM and the optional counter live in the top module.

## Test plan
- Reset with random inputs, Reset_n pulsed low mid-cycle → Out_Valid=0, Out_Ctrl=0, Out_Data=0 at once; In_Ready=1 after release.
- SKID=1, Out_Ready=1, 8 back-to-back inputs Ctrl=i, Data=32'hA0+i → outputs appear in order, one cycle later, one per cycle, In_Ready constant 1.
- SKID=1, Out_Ready low for 4 cycles while In_Valid=1 → exactly two entries held; In_Ready 0 from the second stall cycle; on release, outputs in order with no loss or duplication.
- Flush in TWO, with In_Valid=1 in the same cycle → next cycle Out_Valid=0 and Out_Ctrl=0; Out_Data=0 (CLEAR_ON_FLUSH=1) or unchanged (=0); the flush-cycle input never appears.
- SKID=0, Out_Ready toggling every cycle → In_Ready follows Out_Ready | ~Out_Valid combinationally; no entry lost.
- PIPE_STAGE_STATS_EN defined, Out_Ready=0 for 10 cycles with one entry held → Stall_Count=10. Counter forced near max saturates at 32'hFFFF_FFFF.
